// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// Sits in EX after the ID/EX register. It holds the pipeline via md_stall while
// an operation runs, then commits the 64-bit result to HI/LO. It also accepts
// MTHI/MTLO writes.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// When it is undefined, multiply reuses the 32-iteration shift-add path and no
// hardware multiplier is inferred.
module ex_muldiv (
    input  logic        clk,
    input  logic        resetn,
    input  logic        md_valid,
    input  logic        md_op,
    input  logic        md_sign,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        ex_adv,
    input  logic        flush,
    input  logic [1:0]  hilo_wen,
    input  logic [31:0] hilo_wdata,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // md_stall is a level request. It stays high while the operation that EX
    // holds is unfinished. flush always drops it in the same cycle.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic        neg_quo_q, neg_quo_d;   // negate product / quotient
    logic        neg_rem_q, neg_rem_d;   // negate remainder (sign of dividend)
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] raw;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic        last;

    assign hi = hi_q;
    assign lo = lo_q;

    // Operand magnitudes and one step of the shift-add / restoring-divide datapath
    always_comb begin
        a_mag = (md_sign && md_a[31]) ? -md_a : md_a;
        b_mag = (md_sign && md_b[31]) ? -md_b : md_b;
        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, a_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        // Divide: acc = {remainder, remaining dividend bits / quotient bits}
        div_shift = acc_q[63:31];
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        if (!div_diff[33])
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        else
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
`ifdef MULDIV_FAST_MUL_EN
        last = (cnt_q == 5'd31) || !op_q;
        raw  = op_q ? div_next : ({32'd0, a_q} * {32'd0, b_q});
`else
        last = (cnt_q == 5'd31);
        raw  = op_q ? div_next : mul_next;
`endif
        prod = neg_quo_q ? -raw : raw;
        quo  = neg_quo_q ? -raw[31:0] : raw[31:0];
        rem  = neg_rem_q ? -raw[63:32] : raw[63:32];
    end

    // Control FSM, stall request and HI/LO next-state (completion beats MTHI/MTLO)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        md_stall  = 1'b0;
        if (!flush && hilo_wen[1]) hi_d = hilo_wdata;
        if (!flush && hilo_wen[0]) lo_d = hilo_wdata;
        case (state_q)
            S_IDLE: begin
                md_stall = md_valid && !flush;
                if (md_valid && !flush) begin
                    a_d       = a_mag;
                    b_d       = b_mag;
                    op_d      = md_op;
                    neg_quo_d = md_sign && (md_a[31] ^ md_b[31]);
                    neg_rem_d = md_sign && md_a[31];
                    cnt_d     = 5'd0;
                    acc_d     = {32'd0, md_op ? a_mag : b_mag};
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                md_stall = !flush;
                if (flush || !md_valid) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = raw;
                    cnt_d = cnt_q + 5'd1;
                    if (last) begin
                        hi_d    = op_q ? rem : prod[63:32];
                        lo_d    = op_q ? quo : prod[31:0];
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (ex_adv || flush || !md_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: directed and randomized mult/div operations checked
// against an arithmetic reference model, plus flush, reset and MTHI/MTLO cases.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        resetn;
    logic        md_valid;
    logic        md_op;
    logic        md_sign;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        ex_adv;
    logic        flush;
    logic [1:0]  hilo_wen;
    logic [31:0] hilo_wdata;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    ex_muldiv dut (
        .clk(clk), .resetn(resetn), .md_valid(md_valid), .md_op(md_op),
        .md_sign(md_sign), .md_a(md_a), .md_b(md_b), .ex_adv(ex_adv),
        .flush(flush), .hilo_wen(hilo_wen), .hilo_wdata(hilo_wdata),
        .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    // clock
    always #5 clk = ~clk;

    // Reference model: returns {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_md(input logic op, input logic sign,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!op) begin
            if (sign) return 64'(sa * sb);
            return ua * ub;
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = (sign && a[31]) ? 32'(-sa) : a;
            if (sign && a[31]) begin
                q = -q;
                r = -r;
            end
            return {r, q};
        end
        if (sign) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    // Run one operation from its start cycle to DONE, then advance it.
    // Called at posedge+2ish; leaves at posedge+1 (chain) or posedge+2.
    task automatic run_op(input logic op, input logic sign, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input bit chain, input string name);
        int n;
        int exp_len;
        logic [63:0] e;
        md_op = op; md_sign = sign; md_a = a; md_b = b;
        md_valid = 1'b1; ex_adv = 1'b0; flush = 1'b0;
        exp_q.push_back(exp);
        exp_len = (FAST && !op) ? 2 : 33;
        n = 0;
        #1;
        while (md_stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++;
        if (n != exp_len) begin
            errors++;
            $display("FAIL %s stall_len: got %0d expected %0d", name, n, exp_len);
        end
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, hi, lo, e[63:32], e[31:0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++;
            if (md_stall !== 1'b0 || {hi, lo} !== e) begin
                errors++;
                $display("FAIL %s done_hold: got stall=%b hi=%h lo=%h expected stall=0 hi=%h lo=%h",
                         name, md_stall, hi, lo, e[63:32], e[31:0]);
            end
        end
        ex_adv = 1'b1;
        @(posedge clk); #1;
        ex_adv = 1'b0;
        if (!chain) begin
            md_valid = 1'b0;
            #1;
            checks++;
            if (md_stall !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_stall: got %b expected 0", name, md_stall);
            end
        end
    endtask

    task automatic write_hilo(input logic [1:0] wen, input logic [31:0] data, input logic fl);
        hilo_wen = wen; hilo_wdata = data; flush = fl;
        @(posedge clk); #1;
        hilo_wen = 2'b00; flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; md_valid = 1'b0; md_op = 1'b0; md_sign = 1'b0;
        md_a = '0; md_b = '0; ex_adv = 1'b0; flush = 1'b0;
        hilo_wen = 2'b00; hilo_wdata = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        checks++;
        if (md_stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: got stall=%b hi=%h lo=%h expected 0 0 0", md_stall, hi, lo);
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "multu_max");
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_m7_2");
        run_op(1'b1, 1'b0, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b0, "divu_7_2");
        run_op(1'b1, 1'b0, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b0, "divu_by0");
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FF9C_0000_0001, 1'b0, "div_by0");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "mult_m3_5");
    endtask

    task automatic test_mthi_mtlo();
        write_hilo(2'b11, 32'h0BAD_CAFE, 1'b0);
        write_hilo(2'b10, 32'h0000_1234, 1'b0);
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h expected hi=00001234 lo=0badcafe", hi, lo);
        end
        write_hilo(2'b01, 32'h5555_0000, 1'b1);
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL mtlo_flush: got hi=%h lo=%h expected hi=00001234 lo=0badcafe", hi, lo);
        end
        write_hilo(2'b01, 32'h5555_0000, 1'b0);
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h5555_0000) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h expected hi=00001234 lo=55550000", hi, lo);
        end
    endtask

    task automatic test_flush();
        write_hilo(2'b11, 32'hAAAA_5555, 1'b0);
        md_op = 1'b1; md_sign = 1'b1; md_a = 32'd1000; md_b = 32'd7; md_valid = 1'b1;
        // start cycle T; cnt=10 during cycle T+11
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        #1;
        checks++;
        if (md_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b expected 0", md_stall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++;
        if (hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL flush_hilo: got hi=%h lo=%h expected aaaa5555", hi, lo);
        end
        // md_valid still high: the unit must be idle and restart from scratch
        run_op(1'b1, 1'b1, 32'd1000, 32'd7, ref_md(1'b1, 1'b1, 32'd1000, 32'd7), 1'b0, "flush_restart");
    endtask

    task automatic test_priority();
        logic [63:0] e;
        e = ref_md(1'b1, 1'b0, 32'd12345, 32'd67);
        md_op = 1'b1; md_sign = 1'b0; md_a = 32'd12345; md_b = 32'd67; md_valid = 1'b1;
        repeat (32) @(posedge clk);
        #1 hilo_wen = 2'b11; hilo_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL prio_last_busy: got stall=%b expected 1", md_stall);
        end
        @(posedge clk); #1;
        hilo_wen = 2'b00;
        #1;
        checks++;
        if (md_stall !== 1'b0 || {hi, lo} !== e) begin
            errors++;
            $display("FAIL prio_write: got stall=%b hi=%h lo=%h expected stall=0 hi=%h lo=%h",
                     md_stall, hi, lo, e[63:32], e[31:0]);
        end
        ex_adv = 1'b1;
        @(posedge clk); #1;
        ex_adv = 1'b0; md_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        write_hilo(2'b11, 32'h1357_9BDF, 1'b0);
        md_op = 1'b0; md_sign = 1'b0; md_a = 32'd99; md_b = 32'd77; md_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; md_valid = 1'b0;
        #1;
        checks++;
        if (md_stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b hi=%h lo=%h expected 0 0 0", md_stall, hi, lo);
        end
        run_op(1'b0, 1'b0, 32'd99, 32'd77, 64'd7623, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, "b2b_div_ovf");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, "b2b_mult_min");
        run_op(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFC, 64'h0000_0001_FFFF_FFFE, 1'b0, "b2b_div_9_m4");
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic op, sign;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op   = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            a    = pick_operand();
            b    = pick_operand();
            run_op(op, sign, a, b, ref_md(op, sign, a, b), 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_flush();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so a stuck run still ends with a report
    initial begin
        #400000;
        $display("FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
